// File: rtl/melody_pkg.sv
// Shared types, field widths, the song table and the note-code decoder for melody_sequencer.
package melody_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 4;
  localparam int TABLE_LEN = 16;

  // Entry layout: [7:4] note code, [3:0] duration in ticks; duration 0 terminates the song.
  localparam logic [NOTE_W+DUR_W-1:0] SONG_TABLE [TABLE_LEN] = '{
    8'h12, 8'h51, 8'h03, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [11:0] note_onehot(input logic [NOTE_W-1:0] code);
    logic [11:0] oh;
    oh = '0;
    if (code >= 4'd1 && code <= 4'd11) oh = 12'b1 << code;
    return oh;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick on count TICK_DIV-1, then wraps.
// Counts only while en is high; clr (or reset) forces the count back to 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Walks the song table, driving a registered one-hot note code for duration*TICK_DIV cycles per entry.
// First note appears two cycles after start; optional silent gap after each note; stop aborts immediately.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned SONG_LEN  = 16,
  localparam int IDX_W = $clog2(SONG_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [11:0]      note_oh,
  output logic             sound_en,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx
);

  localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [11:0]      note_n;
  logic             snd_n, done_n;
  logic [DUR_W-1:0] dur_q, dur_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             tick, pre_en;
  logic             advance, end_song;

  logic [NOTE_W+DUR_W-1:0] entry;
  logic [NOTE_W-1:0]       entry_code;
  logic [DUR_W-1:0]        entry_dur;

  assign entry      = SONG_TABLE[idx];
  assign entry_code = entry[NOTE_W+DUR_W-1:DUR_W];
  assign entry_dur  = entry[DUR_W-1:0];

  // Prescaler runs only while timing a note or a gap, so every note starts from a clean phase.
  assign pre_en = (state_q == S_PLAY) || (state_q == S_GAP);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (!pre_en),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state_q;
    idx_n    = idx;
    note_n   = note_oh;
    snd_n    = sound_en;
    done_n   = 1'b0;
    dur_n    = dur_q;
    gap_n    = gap_q;
    advance  = 1'b0;
    end_song = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      S_LOAD: begin
        if (entry_dur == '0) begin
          end_song = 1'b1;
        end else begin
          state_n = S_PLAY;
          note_n  = note_onehot(entry_code);
          snd_n   = (note_onehot(entry_code) != '0);
          dur_n   = entry_dur;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            note_n = '0;
            snd_n  = 1'b0;
            if (GAP_TICKS > 0) begin
              state_n = S_GAP;
              gap_n   = GAP_W'(GAP_TICKS);
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_n = dur_q - DUR_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(1)) advance = 1'b1;
          else                    gap_n = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
      default: state_n = S_IDLE;
    endcase

    // Leaving the last entry without a marker is treated exactly like hitting one.
    if (advance) begin
      if (idx == LAST_IDX) begin
        end_song = 1'b1;
      end else begin
        state_n = S_LOAD;
        idx_n   = idx + IDX_W'(1);
      end
    end

    if (end_song) begin
      if (loop_en) begin
        state_n = S_LOAD;
        idx_n   = '0;
      end else begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
    end

    if (stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
      note_n  = '0;
      snd_n   = 1'b0;
      done_n  = 1'b0;
      dur_n   = '0;
      gap_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx      <= '0;
      note_oh  <= '0;
      sound_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dur_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_n;
      idx      <= idx_n;
      note_oh  <= note_n;
      sound_en <= snd_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
      dur_q    <= dur_n;
      gap_q    <= gap_n;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a timeline model built from the song table is compared every cycle,
// with literal expectations pinning key points of both the model and the DUT.
module tb_melody_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 1;
  localparam int LEN  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [11:0] note_oh;
  logic        sound_en, busy, done;
  logic [3:0]  idx;

  melody_sequencer #(.TICK_DIV(TICK), .GAP_TICKS(GAP), .SONG_LEN(LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .note_oh  (note_oh),
    .sound_en (sound_en),
    .busy     (busy),
    .done     (done),
    .idx      (idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] note;
    logic        snd;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } obs_t;

  logic [7:0] tbl [LEN];
  obs_t exp_q[$];
  obs_t exp_log[$];
  obs_t act_log[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  function automatic obs_t mk(logic [11:0] n, logic s, logic b, logic d, logic [3:0] i);
    obs_t o;
    o.note = n; o.snd = s; o.busy = b; o.done = d; o.idx = i;
    return o;
  endfunction

  task automatic push_n(obs_t o, int n);
    repeat (n) exp_q.push_back(o);
  endtask

  // One pass through the table as a list of per-cycle outputs: LOAD cycle, note, gap, ...
  task automatic build_pass(output int end_idx);
    logic [3:0]  code, d;
    logic [11:0] oh;
    end_idx = LEN - 1;
    for (int i = 0; i < LEN; i++) begin
      code = tbl[i][7:4];
      d    = tbl[i][3:0];
      push_n(mk(12'h000, 1'b0, 1'b1, 1'b0, 4'(i)), 1);
      if (d == 4'd0) begin
        end_idx = i;
        return;
      end
      oh = (code >= 4'd1 && code <= 4'd11) ? (12'b1 << code) : 12'b0;
      push_n(mk(oh, oh != 12'h000, 1'b1, 1'b0, 4'(i)), int'(d) * TICK);
      if (GAP > 0) push_n(mk(12'h000, 1'b0, 1'b1, 1'b0, 4'(i)), GAP * TICK);
    end
  endtask

  task automatic build(bit lp_end, int stop_at, int total);
    int e;
    exp_q.delete();
    act_log.delete();
    build_pass(e);
    if (lp_end) build_pass(e);
    else        push_n(mk(12'h000, 1'b0, 1'b1, 1'b1, 4'(e)), 1);
    if (stop_at >= 0) while (exp_q.size() > stop_at) void'(exp_q.pop_back());
    while (exp_q.size() < total) exp_q.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 4'd0));
    while (exp_q.size() > total) void'(exp_q.pop_back());
    exp_log = exp_q;
  endtask

  always @(negedge clk) begin : compare
    obs_t a, e;
    if (chk_en) begin
      a = mk(note_oh, sound_en, busy, done, idx);
      act_log.push_back(a);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle %0d: got note=%h snd=%b busy=%b done=%b idx=%0d, want note=%h snd=%b busy=%b done=%b idx=%0d",
                   act_log.size() - 1, a.note, a.snd, a.busy, a.done, a.idx,
                   e.note, e.snd, e.busy, e.done, e.idx);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // t counts edges after the one that samples start; inputs set for edge t are driven just after edge t-1.
  task automatic run(bit lp_a, int sw_at, bit lp_b, int stop_at, int extra_start, int total);
    build(lp_b, stop_at, total);
    @(posedge clk); #1;
    start = 1'b1;
    loop_en = lp_a;
    for (int t = 1; t < total; t++) begin
      @(posedge clk); #1;
      chk_en  = 1'b1;
      start   = (t == stop_at) || (t == extra_start);
      stop    = (t == stop_at);
      loop_en = (t >= sw_at) ? lp_b : lp_a;
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    tbl = '{8'h12, 8'h51, 8'h03, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_note", note_oh, 12'h000);
    chk("rst_snd", sound_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", idx, 4'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset during the first note
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_note", note_oh, 12'h002);
    chk("pre_rst_busy", busy, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_note", note_oh, 12'h000);
    chk("midrst_snd", sound_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    // A: loop_en high early but low at the marker -> done; extra start while busy is ignored
    run(1'b1, 30, 1'b0, -1, 20, 56);
    chk("A_m_note1", exp_log[1].note, 12'h002);
    chk("A_m_note14", exp_log[14].note, 12'h020);
    chk("A_m_rest23", exp_log[23].snd, 1'b0);
    chk("A_m_note40", exp_log[40].note, 12'h800);
    chk("A_m_idx48", exp_log[48].idx, 4'd4);
    chk("A_m_done49", exp_log[49].done, 1'b1);
    chk("A_m_busy50", exp_log[50].busy, 1'b0);
    chk("A_note8", act_log[8].note, 12'h002);
    chk("A_gap9", act_log[9].note, 12'h000);
    chk("A_done49", act_log[49].done, 1'b1);
    chk("A_done50", act_log[50].done, 1'b0);
    chk("A_idx50", act_log[50].idx, 4'd0);

    // B: loop_en low early but high at the marker -> replay from entry 0, then stop
    run(1'b0, 30, 1'b1, 60, -1, 66);
    chk("B_m_idx49", exp_log[49].idx, 4'd0);
    chk("B_m_done49", exp_log[49].done, 1'b0);
    chk("B_note50", act_log[50].note, 12'h002);
    chk("B_busy60", act_log[60].busy, 1'b0);

    // C: stop together with start during the second note
    run(1'b0, 100, 1'b0, 16, -1, 24);
    chk("C_note15", act_log[15].note, 12'h020);
    chk("C_busy16", act_log[16].busy, 1'b0);
    chk("C_note16", act_log[16].note, 12'h000);
    chk("C_done16", act_log[16].done, 1'b0);
    chk("C_busy23", act_log[23].busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
